// File: rtl/gb_serial_link_pkg.sv
// Shared definitions for the serial link port: FSM encoding, SC bit layout and
// default register addresses.
package gb_serial_link_pkg;

    typedef logic [1:0] serial_state_t;

    localparam serial_state_t IDLE = 2'd0;
    localparam serial_state_t LOW  = 2'd1;
    localparam serial_state_t HIGH = 2'd2;
    localparam serial_state_t EXT  = 2'd3;

    localparam int unsigned SC_START  = 7;
    localparam int unsigned SC_CLKSEL = 0;

    localparam logic [15:0] DEFAULT_ADDR_SB = 16'hFF01;
    localparam logic [15:0] DEFAULT_ADDR_SC = 16'hFF02;

endpackage

// File: rtl/gb_serial_link_sync2.sv
// Two-flop synchronizer for asynchronous link inputs; resets to the idle-high
// line level.
module gb_serial_link_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/gb_serial_link.sv
// Serial link port (SB/SC): shifts a byte out on sout while shifting one in from
// sin, clocked internally at CLK_DIV or by the external link clock.
module gb_serial_link
    import gb_serial_link_pkg::*;
#(
    parameter int unsigned CLK_DIV = 512,
    parameter logic [15:0] ADDR_SB = DEFAULT_ADDR_SB,
    parameter logic [15:0] ADDR_SC = DEFAULT_ADDR_SC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        sel,
    input  logic        sin,
    input  logic        sclk_in,
    output logic        sout,
    output logic        sclk_out,
    output logic        sclk_oe,
    output logic        irq_serial
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    serial_state_t    state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sb_q, sb_d;
    logic             clksel_q, clksel_d;
    logic             sout_q, sout_d;
    logic             irq_q, irq_d;
    logic             sclk_prev_q;

    logic sin_sync, sclk_sync;

    gb_serial_link_sync2 u_sync_sin (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (sin_sync)
    );

    gb_serial_link_sync2 u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk_in),
        .q   (sclk_sync)
    );

    logic hit_sb, hit_sc, sb_wr, sc_wr, busy, sclk_rise, sclk_fall;
    logic [7:0] sc_rd;

    assign hit_sb    = (addr == ADDR_SB);
    assign hit_sc    = (addr == ADDR_SC);
    assign sel       = hit_sb | hit_sc;
    assign sb_wr     = wr_en & hit_sb;
    assign sc_wr     = wr_en & hit_sc;
    assign busy      = (state_q != IDLE);
    assign sclk_rise = sclk_sync & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync & sclk_prev_q;

    always_comb begin
        sc_rd            = 8'h7E;
        sc_rd[SC_START]  = busy;
        sc_rd[SC_CLKSEL] = clksel_q;
        rdata            = 8'hFF;
        if (rd_en && hit_sb) begin
            rdata = sb_q;
        end else if (rd_en && hit_sc) begin
            rdata = sc_rd;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sb_d      = sb_q;
        sout_d    = sout_q;
        clksel_d  = clksel_q;
        irq_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sc_wr && wdata[SC_START]) begin
                    sout_d  = sb_q[7];
                    state_d = wdata[SC_CLKSEL] ? LOW : EXT;
                end
            end
            LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    state_d   = HIGH;
                    sb_d      = {sb_q[6:0], sin_sync};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_cnt_q == 4'd8) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        irq_d     = 1'b1;
                    end else begin
                        // A clksel change made mid-byte takes effect here.
                        state_d = clksel_q ? LOW : EXT;
                        sout_d  = sb_q[7];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            EXT: begin
                if (sclk_fall) begin
                    sout_d = sb_q[7];
                end
                if (sclk_rise) begin
                    sb_d      = {sb_q[6:0], sin_sync};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        irq_d     = 1'b1;
                    end else if (clksel_q) begin
                        state_d = LOW;
                        div_d   = '0;
                        sout_d  = sb_q[6];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sb_wr && !busy) begin
            sb_d = wdata;
        end
        if (sc_wr) begin
            clksel_d = wdata[SC_CLKSEL];
            // Abort: drop any progress made this cycle and keep the partial shift.
            if (!wdata[SC_START] && busy) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                div_d     = '0;
                sb_d      = sb_q;
                sout_d    = sout_q;
                irq_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            sb_q        <= 8'h00;
            clksel_q    <= 1'b0;
            sout_q      <= 1'b1;
            irq_q       <= 1'b0;
            sclk_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            sb_q        <= sb_d;
            clksel_q    <= clksel_d;
            sout_q      <= sout_d;
            irq_q       <= irq_d;
            sclk_prev_q <= sclk_sync;
        end
    end

    assign sout       = sout_q;
    assign sclk_out   = (state_q != LOW);
    assign sclk_oe    = clksel_q;
    assign irq_serial = irq_q;

endmodule

// File: doc/gb_serial_link.md
Name: gb_serial_link

Overview:
- Memory-mapped serial link port (SB at 0xFF01, SC at 0xFF02) that responds to CPU datapath bus cycles.
- Shifts one byte out on sout and simultaneously one byte in on sin. Uses either an internal 8192 Hz clock or the external link clock.
- Raises a one-cycle serial interrupt request to the interrupt controller when the byte completes.
- Sits beside the datapath on the I/O register bus. It is the target-side counterpart of the CPU's MAR/MDR accesses.

Parameters:
- CLK_DIV, 512: system clocks per serial bit; 4.194304 MHz / 512 = 8192 Hz. Must be even and ≥4.
- ADDR_SB, 16'hFF01: serial data register address.
- ADDR_SC, 16'hFF02: serial control register address.

Ports:
- clk  in  1  system clock, 4.19 MHz
- rst  in  1  asynchronous, active-low reset
- addr  in  16  CPU bus address
- wr_en  in  1  CPU write strobe, one cycle
- rd_en  in  1  CPU read strobe
- wdata  in  8  CPU write data
- rdata  out  8  read data, combinational
- sel  out  1  addr matches ADDR_SB or ADDR_SC
- sin  in  1  serial data in, asynchronous
- sclk_in  in  1  external serial clock, asynchronous
- sout  out  1  serial data out
- sclk_out  out  1  internal serial clock output
- sclk_oe  out  1  1 when the internal clock drives the link
- irq_serial  out  1  one-cycle transfer-complete pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - SB=00; SC.start=0; SC.clksel=0.
  - sout=1, sclk_out=1, sclk_oe=0, irq_serial=0.
  - FSM=IDLE; bit counter=0; divider=0; synchronizers=1.
- Registers:
  - SC bit7 is start; bit0 is clksel (1 = internal clock).
  - SC reads as {start,6'b111111,clksel}.
  - rdata = SB or SC when rd_en and sel, else 8'hFF.
  - Simultaneous rd_en and wr_en: the write takes effect at the clock edge; rdata shows the pre-write value.
- sin and sclk_in each pass through a 2-flop synchronizer before use.
- sclk_oe = SC.clksel at all times.
- FSM states: IDLE, LOW, HIGH (internal clock); EXT (external clock).
- IDLE:
  - A write to SC with wdata[7]=1 sets start and loads sout<=SB[7] on the same edge.
  - Next state is LOW if wdata[0]=1, else EXT.
- LOW:
  - sclk_out=0 for CLK_DIV/2 cycles.
  - Then go to HIGH and shift in: SB<={SB[6:0],sin_sync}; bit counter +1.
- HIGH:
  - sclk_out=1 for CLK_DIV/2 cycles.
  - If bit counter=8: go to IDLE, clear start, pulse irq_serial for that one cycle.
  - Otherwise: go to LOW and load sout<=SB[7].
- Internal-clock timing: start written at cycle 0 → LOW entered at cycle 1 → irq_serial high in cycle 1+8*CLK_DIV.
- EXT:
  - Synchronized sclk_in falling edge: sout<=SB[7].
  - Synchronized sclk_in rising edge: SB<={SB[6:0],sin_sync}; bit counter +1.
  - On the 8th rising edge: clear start, pulse irq_serial in the following cycle, go to IDLE.
  - No timeout; EXT waits indefinitely.
- Idle line levels: sout holds its last value; sclk_out=1.
- Boundary conditions:
  - Write to SB while not IDLE: ignored.
  - Write to SC with wdata[7]=0 while not IDLE: abort. Go to IDLE with no irq; SB keeps the partial shift; bit counter clears; sclk_out=1.
  - Write to SC with wdata[7]=1 while busy: clksel updates; the transfer continues in its current state without restart. The mode switch takes effect at the next bit boundary.
  - Reset mid-transfer: all state returns to reset values immediately; no irq.
  - Divider wraps to 0 at every phase change.
  - Bit counter is 4 bits; it clears whenever the FSM enters IDLE.

Decomposition:
- Shared package: serial_state_t enum {IDLE,LOW,HIGH,EXT}, SC bit-position constants, ADDR_SB/ADDR_SC defaults.
- One sub-module: sync2 (2-flop synchronizer, reset value 1), instantiated for sin and sclk_in.

Test Plan (CLK_DIV=8):
1. Reset values:
   - Stimulus: hold rst=0, then read 0xFF01 and 0xFF02.
   - Required: rdata=00 then 7E; sout=1, sclk_out=1, irq_serial=0, sclk_oe=0.
2. Internal-clock transfer:
   - Stimulus: write SB=A5; drive sin so that 3C is shifted in MSB first; write SC=81 at cycle 0.
   - Required: sout sequence 1,0,1,0,0,1,0,1; eight sclk_out low pulses, 4 cycles each.
   - Required: irq_serial high only in cycle 65; SB reads 3C; SC reads FF→7F.
3. External-clock transfer:
   - Stimulus: write SB=F0, SC=80; drive sclk_in with 8 pulses of 20 cycles each, sin=1.
   - Required: sclk_oe=0; sout follows F0 bits on falling edges.
   - Required: irq_serial pulses 3 cycles after the 8th sclk_in rise; SB=FF.
4. Abort:
   - Stimulus: internal transfer of SB=A5 with sin=0; write SC=01 after 3 rising edges.
   - Required: FSM goes to IDLE; no irq ever; sclk_out=1; SB=28.
5. Ignored SB write and unmapped read:
   - Stimulus: write SB=00 mid-transfer; read 0xFF03.
   - Required: the shift continues unaffected; the 0xFF03 read gives sel=0, rdata=FF.
6. Reset mid-transfer:
   - Stimulus: pull rst low at bit 4.
   - Required: outputs return to reset values asynchronously; no irq; a new SC=81 completes normally after reset.
